// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point SDF FFT pipeline: datapath widths,
// the stage-controller state type and the twiddle stride helper.
package fft_pkg;

  localparam int unsigned DATA_W = 15;
  localparam int unsigned N_FFT  = 32;
  localparam int unsigned TW_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sdf_state_e;

  // Twiddle index step between consecutive load-half samples of a stage.
  function automatic int unsigned tw_stride(input int unsigned n, input int unsigned delay);
    return n / (2 * delay);
  endfunction

endpackage

// File: rtl/sdf_tw_addr_gen.sv
// Twiddle ROM address generator shared by all SDF stage controllers.
// The sum path (bf_sel_i = 1) always uses W^0; the difference path uses
// W_N^(k * N/(2*DELAY)), wrapped to the ROM address width.
module sdf_tw_addr_gen #(
  parameter int unsigned N     = fft_pkg::N_FFT,
  parameter int unsigned DELAY = 8,
  parameter int unsigned TW_W  = fft_pkg::TW_W,
  localparam int unsigned KW   = (DELAY > 1) ? $clog2(DELAY) : 1
) (
  input  logic [KW-1:0]   k_i,
  input  logic            bf_sel_i,
  output logic [TW_W-1:0] tw_addr_o
);
  import fft_pkg::*;

  localparam int unsigned STRIDE = tw_stride(N, DELAY);

  logic [TW_W-1:0] prod;

  // Product is formed at ROM width directly; truncation is modulo 2^TW_W either way.
  always_comb begin
    prod      = TW_W'(k_i) * TW_W'(STRIDE);
    tw_addr_o = bf_sel_i ? '0 : prod;
  end

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF stage: handshakes the input stream, drives
// the delay-line shift enable, butterfly select and twiddle address, and
// drains the delay line for DELAY cycles after the final frame.
// Optional build macro SDF_FRAME_CNT_EN adds a saturating 16-bit frame_cnt.
module sdf_stage_ctrl #(
  parameter int unsigned N     = fft_pkg::N_FFT,
  parameter int unsigned DELAY = 8,
  parameter int unsigned TW_W  = fft_pkg::TW_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic            sr_en,
  output logic            bf_sel,
  output logic [TW_W-1:0] tw_addr,
  output logic            out_valid,
  output logic            out_first,
  output logic            busy,
  output logic            frame_err
`ifdef SDF_FRAME_CNT_EN
  ,
  output logic [15:0]     frame_cnt
`endif
);
  import fft_pkg::*;

  localparam int unsigned CW = $clog2(2 * DELAY);
  localparam int unsigned KW = (DELAY > 1) ? $clog2(DELAY) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(2 * DELAY - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(DELAY);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DELAY - 1);

  sdf_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          primed_q, primed_d;
  logic          frame_err_q, frame_err_d;
  logic          accept;
  logic [KW-1:0] k;

  // With DELAY = 1 the counter is only the butterfly bit, so k is always 0.
  if (DELAY > 1) begin : g_k
    assign k = cnt_q[KW-1:0];
  end else begin : g_k_zero
    assign k = '0;
  end

  // Handshake and per-cycle datapath controls from state and counter.
  always_comb begin
    in_ready  = (state_q != DRAIN);
    busy      = (state_q != IDLE);
    accept    = in_valid & in_ready & ~rst;
    sr_en     = 1'b0;
    bf_sel    = 1'b0;
    out_valid = 1'b0;
    out_first = 1'b0;
    if (state_q == DRAIN) begin
      sr_en     = 1'b1;
      out_valid = 1'b1;
    end else begin
      sr_en     = accept;
      bf_sel    = cnt_q[CW-1];
      out_valid = accept & (bf_sel | primed_q);
      out_first = out_valid & (cnt_q == CNT_HALF);
    end
  end

  sdf_tw_addr_gen #(
    .N     (N),
    .DELAY (DELAY),
    .TW_W  (TW_W)
  ) u_tw_addr_gen (
    .k_i       (k),
    .bf_sel_i  (bf_sel),
    .tw_addr_o (tw_addr)
  );

  // Next-state: IDLE and RUN share sample handling since IDLE sits at cnt = 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    frame_err_d = frame_err_q;
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          state_d = RUN;
          if (bf_sel) begin
            primed_d = 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (in_last) begin
              state_d = DRAIN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (in_last) begin
              frame_err_d = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          primed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        primed_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

`ifdef SDF_FRAME_CNT_EN
  logic        wrap;
  logic [15:0] frame_cnt_q;

  assign wrap = accept & (cnt_q == CNT_LAST);

  // Completed-frame counter, saturating at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (wrap && (frame_cnt_q != '1)) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: a DELAY = 8 and a DELAY = 1 instance share one
// input stream; each is checked every cycle against a sample-position model.
module tb_sdf_stage_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;

  logic [1:0] rdy, sr, bf, ov, of, bsy, ferr;
  logic [3:0] tw [2];
`ifdef SDF_FRAME_CNT_EN
  logic [15:0] fc [2];
`endif

  int dly [2] = '{8, 1};

  // Reference model: position of the next sample within its 2*D frame,
  // remaining drain cycles, and flags derived from the stream history.
  int          pos [2];
  int          drain_left [2];
  bit          running [2];
  bit          primed [2];
  bit          err [2];
  int unsigned frames [2];
  int          n_ov [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdf_stage_ctrl #(.N(32), .DELAY(8), .TW_W(4)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy[0]), .sr_en(sr[0]), .bf_sel(bf[0]), .tw_addr(tw[0]),
    .out_valid(ov[0]), .out_first(of[0]), .busy(bsy[0]), .frame_err(ferr[0])
`ifdef SDF_FRAME_CNT_EN
    , .frame_cnt(fc[0])
`endif
  );

  sdf_stage_ctrl #(.N(32), .DELAY(1), .TW_W(4)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy[1]), .sr_en(sr[1]), .bf_sel(bf[1]), .tw_addr(tw[1]),
    .out_valid(ov[1]), .out_first(of[1]), .busy(bsy[1]), .frame_err(ferr[1])
`ifdef SDF_FRAME_CNT_EN
    , .frame_cnt(fc[1])
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pos[i]        = 0;
      drain_left[i] = 0;
      running[i]    = 1'b0;
      primed[i]     = 1'b0;
      err[i]        = 1'b0;
      frames[i]     = 0;
    end
  endtask

  task automatic check_reset_values(input string where);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s.d%0d.in_ready", where, dly[i]), 32'(rdy[i]), 32'd1);
      check_eq($sformatf("%s.d%0d.sr_en", where, dly[i]), 32'(sr[i]), 32'd0);
      check_eq($sformatf("%s.d%0d.bf_sel", where, dly[i]), 32'(bf[i]), 32'd0);
      check_eq($sformatf("%s.d%0d.tw_addr", where, dly[i]), 32'(tw[i]), 32'd0);
      check_eq($sformatf("%s.d%0d.out_valid", where, dly[i]), 32'(ov[i]), 32'd0);
      check_eq($sformatf("%s.d%0d.out_first", where, dly[i]), 32'(of[i]), 32'd0);
      check_eq($sformatf("%s.d%0d.busy", where, dly[i]), 32'(bsy[i]), 32'd0);
      check_eq($sformatf("%s.d%0d.frame_err", where, dly[i]), 32'(ferr[i]), 32'd0);
`ifdef SDF_FRAME_CNT_EN
      check_eq($sformatf("%s.d%0d.frame_cnt", where, dly[i]), 32'(fc[i]), 32'd0);
`endif
    end
  endtask

  // Asynchronous reset between clock edges, with in_valid held high to
  // show that nothing is accepted while reset is asserted.
  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_values("rst_mid");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
  endtask

  // One clock: drive inputs, check every output against the model, then
  // advance the model on the rising edge.
  task automatic step(input bit v, input bit l);
    bit acc_s [2];
    bit bf_s [2];
    @(negedge clk);
    in_valid = v;
    in_last  = l;
    #1;
    for (int i = 0; i < 2; i++) begin
      int d, stride, k, e_tw;
      bit drn, acc, e_sr, e_bf, e_ov, e_of;
      d      = dly[i];
      stride = 32 / (2 * d);
      drn    = (drain_left[i] > 0);
      acc    = v && !drn;
      if (drn) begin
        e_sr = 1'b1;
        e_bf = 1'b0;
        k    = d - drain_left[i];
        e_ov = 1'b1;
        e_of = 1'b0;
      end else begin
        e_sr = acc;
        e_bf = (pos[i] >= d);
        k    = pos[i] % d;
        e_ov = acc && (e_bf || primed[i]);
        e_of = e_ov && (pos[i] == d);
      end
      e_tw = e_bf ? 0 : (k * stride) % 16;
      check_eq($sformatf("d%0d.in_ready", d), 32'(rdy[i]), 32'(!drn));
      check_eq($sformatf("d%0d.sr_en", d), 32'(sr[i]), 32'(e_sr));
      check_eq($sformatf("d%0d.bf_sel", d), 32'(bf[i]), 32'(e_bf));
      check_eq($sformatf("d%0d.tw_addr", d), 32'(tw[i]), 32'(e_tw));
      check_eq($sformatf("d%0d.out_valid", d), 32'(ov[i]), 32'(e_ov));
      check_eq($sformatf("d%0d.out_first", d), 32'(of[i]), 32'(e_of));
      check_eq($sformatf("d%0d.busy", d), 32'(bsy[i]), 32'(running[i] || drn));
      check_eq($sformatf("d%0d.frame_err", d), 32'(ferr[i]), 32'(err[i]));
`ifdef SDF_FRAME_CNT_EN
      check_eq($sformatf("d%0d.frame_cnt", d), 32'(fc[i]), frames[i]);
`endif
      if (e_ov) n_ov[i]++;
      acc_s[i] = acc;
      bf_s[i]  = e_bf;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int d;
      d = dly[i];
      if (drain_left[i] > 0) begin
        drain_left[i]--;
        if (drain_left[i] == 0) begin
          running[i] = 1'b0;
          primed[i]  = 1'b0;
          pos[i]     = 0;
        end
      end else if (acc_s[i]) begin
        running[i] = 1'b1;
        if (bf_s[i]) primed[i] = 1'b1;
        if (pos[i] == 2 * d - 1) begin
          pos[i] = 0;
          if (frames[i] != 32'hFFFF) frames[i]++;
          if (l) drain_left[i] = d;
        end else begin
          pos[i]++;
          if (l) err[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic burst(input int n, input bit last_at_end);
    for (int j = 1; j <= n; j++) step(1'b1, last_at_end && (j == n));
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    n_ov[0] = 0;
    n_ov[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst_init");
    #1 rst = 1'b0;

    // Partial frame then reset at cnt = 5; restart must be from cnt = 0.
    idle(2);
    burst(5, 1'b0);
    pulse_reset();
    idle(1);

    // Single 16-sample frame with in_last on the 16th, then drain.
    burst(16, 1'b1);
    idle(10);

    // Two frames back to back; total outputs equal the sample count.
    n_ov[0] = 0;
    n_ov[1] = 0;
    burst(32, 1'b1);
    idle(10);
    check_eq("d8.total_out_valid", 32'(n_ov[0]), 32'd32);
    check_eq("d1.total_out_valid", 32'(n_ov[1]), 32'd32);

    // Stall of 3 cycles at cnt = 4.
    burst(4, 1'b0);
    idle(3);
    burst(12, 1'b1);
    idle(10);

    // in_last at cnt = 6 is a framing error; streaming continues.
    burst(7, 1'b1);
    burst(9, 1'b1);
    idle(10);

    // Random traffic, including in_valid held during drain.
    for (int c = 0; c < 1500; c++) begin
      bit v, l;
      v = ($urandom_range(0, 3) != 0);
      l = v && ($urandom_range(0, 7) == 0);
      step(v, l);
      if (c == 700) pulse_reset();
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
